xor_pipe: RTL and testbench
===========================

# xor_pipe

Parametrised, pipelined successor to the single-bit registered XOR cell. It combines two WIDTH-bit operands per beat, either as a plain bitwise XOR or as a running XOR accumulation. Results pass through a STAGES-deep register pipeline with a valid/ready handshake and full-pipeline stall. It is the timing-characterisation target for multi-stage setup/hold checks in the VCD assertion flow.

## Interface
- WIDTH, 8, operand and result width in bits, 1..64
- STAGES, 2, pipeline depth in register stages (latency), 1..8
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  beat accepted when in_valid && in_ready at a rising edge
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- mode  input  1  0 = bitwise XOR; 1 = accumulate; sampled per accepted beat
- acc_clr  input  1  clear accumulator (synchronous, independent of in_valid)
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  result
- out_parity  output  1  reduction XOR of out_data (see Configuration)

## Operation
- Pipeline: STAGES register slots, each holding valid bit plus data. Slot 0 is loaded on accept; the last slot drives out_valid/out_data.
- Stall: `advance = !out_valid || out_ready`. When advance is 1, all slots shift one position per cycle, and slot 0 loads the new beat or a bubble (valid=0). When advance is 0, every slot holds.
- in_ready = advance. This is combinational from out_valid/out_ready; there is no in_valid -> in_ready path.
- Mode 0: slot-0 data = a ^ b. The accumulator is untouched.
- Mode 1: acc_next = acc ^ a ^ b; slot-0 data = acc_next; acc <= acc_next.
- acc_clr: acc <= 0 on the edge.
- acc_clr together with an accepted mode-1 beat: the clear applies first. Result = a ^ b and acc <= a ^ b.
- acc_clr together with an accepted mode-0 beat: result = a ^ b and acc <= 0.
- Accumulator updates only on accepted beats; stalled or offered-but-unaccepted beats leave acc unchanged.
- Bubbles carry data 0 and never alter acc.
- Arithmetic: pure bitwise XOR, WIDTH bits, no carries; the accumulator is WIDTH bits.

## Timing
- Reset (rst high at an edge) sets:
  - every slot valid = 0 and data = 0
  - acc = 0
  - out_valid = 0, out_data = 0, out_parity = 0
  - in_ready = 1 in the first cycle after reset.
- Reset overrides acc_clr, in_valid and any in-flight beats. In-flight results are discarded and none appear after reset.
- Latency: a beat accepted at edge N appears on out_data with out_valid = 1 after edge N+STAGES-1, i.e. visible in cycle N+STAGES-1 when STAGES = 1 counts as one register. Minimum accept-to-output is exactly STAGES edges.
- Throughput: one beat per cycle when out_ready is held at 1.
- Backpressure: while out_valid && !out_ready:
  - out_data is stable
  - in_ready = 0
  - no slot changes.
- Full pipeline: STAGES beats held in flight with out_ready = 0; no beat is lost or duplicated.
- When out_ready rises, the first transfer and a new accept occur on the same edge.
- Outputs are registered except in_ready.

## Configuration
- XOR_PIPE_PARITY_EN defined:
  - each slot carries one extra parity bit computed at slot 0 (^ of the slot-0 data)
  - out_parity = ^out_data, aligned with out_data, reset 0.
- Not defined:
  - the out_parity port still exists and is tied to 0
  - no parity registers are instantiated.

## Test plan
- Reset then mode 0, WIDTH=8, STAGES=2, out_ready=1: beats a=8'hF0/b=8'h0F, then a=8'hAA/b=8'hAA. Required: out_data=8'hFF two edges after the first accept, then 8'h00 on the next cycle, with out_valid=1 for exactly two cycles.
- Mode 1 accumulation, beats (01,02), (04,00), (10,10). Required: outputs 03, 07, 07 in order, and acc=07.
- acc_clr asserted together with mode-1 beat (3C,00) while acc=FF. Required: output 3C and acc=3C. acc_clr alone with no beat: acc becomes 00 and no output appears.
- Backpressure: out_ready=0 while 4 beats are offered, STAGES=2. Required:
  - exactly 2 beats accepted, then in_ready=0
  - out_data held stable
  - on release, all results emerge in order with no loss or duplication.
- Reset mid-operation with 2 beats in flight. Required: out_valid=0 and out_data=00 on the next cycle, no stale result afterwards, and acc=00.
- With XOR_PIPE_PARITY_EN: result 8'h07 gives out_parity=1 and result 8'h03 gives out_parity=0. Without the macro, out_parity is constantly 0.

Source files
------------

// File: rtl/xor_pipe.sv
// Pipelined WIDTH-bit XOR / running-XOR accumulator with valid/ready handshake and full-pipeline stall.
// Optional per-slot parity is enabled by defining XOR_PIPE_PARITY_EN.
module xor_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity
);

    logic             valid_reg [STAGES];
    logic [WIDTH-1:0] data_reg  [STAGES];
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] slot0_data;
    logic             advance;
    logic             accept;

    assign advance   = !valid_reg[STAGES-1] || out_ready;
    assign accept    = in_valid && advance;
    assign in_ready  = advance;
    assign out_valid = valid_reg[STAGES-1];
    assign out_data  = data_reg[STAGES-1];

    // A clear coinciding with a mode-1 beat takes effect before the beat is folded in.
    always_comb begin
        acc_base   = acc_clr ? '0 : acc_reg;
        acc_next   = acc_base ^ a ^ b;
        slot0_data = mode ? acc_next : (a ^ b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (accept && mode) begin
            acc_reg <= acc_next;
        end else if (acc_clr) begin
            acc_reg <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg[0] <= 1'b0;
            data_reg[0]  <= '0;
        end else if (advance) begin
            valid_reg[0] <= accept;
            data_reg[0]  <= accept ? slot0_data : '0;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= '0;
                end else if (advance) begin
                    valid_reg[gi] <= valid_reg[gi-1];
                    data_reg[gi]  <= data_reg[gi-1];
                end
            end
        end
    endgenerate

`ifdef XOR_PIPE_PARITY_EN
    logic parity_reg [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_reg[0] <= 1'b0;
        end else if (advance) begin
            parity_reg[0] <= accept ? ^slot0_data : 1'b0;
        end
    end

    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_par
            always_ff @(posedge clk) begin
                if (rst) begin
                    parity_reg[gi] <= 1'b0;
                end else if (advance) begin
                    parity_reg[gi] <= parity_reg[gi-1];
                end
            end
        end
    endgenerate

    assign out_parity = parity_reg[STAGES-1];
`else
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_xor_pipe.sv
// Scoreboard bench for xor_pipe (WIDTH=8, STAGES=2): expected results queued at accept,
// compared against results captured at each output transfer.
module tb_xor_pipe;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_parity;

    xor_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .mode       (mode),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_parity (out_parity)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_q[$];
    logic             got_par_q[$];
    logic [WIDTH-1:0] model_acc = '0;
    logic             last_in = 1'b0;

    function automatic logic exp_par(input logic [WIDTH-1:0] v);
`ifdef XOR_PIPE_PARITY_EN
        return ^v;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: sample handshakes at negedge, update model, then step past the rising edge.
    task automatic tick();
        logic [WIDTH-1:0] r;
        @(negedge clk);
        last_in = in_valid && in_ready;
        if (rst) begin
            exp_q.delete();
            got_q.delete();
            got_par_q.delete();
            model_acc = '0;
        end else begin
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_par_q.push_back(out_parity);
                $display("xfer: out_data=%02h out_parity=%0b", out_data, out_parity);
            end
            if (last_in) begin
                if (mode) begin
                    r = (acc_clr ? '0 : model_acc) ^ a ^ b;
                    model_acc = r;
                end else begin
                    r = a ^ b;
                    if (acc_clr) model_acc = '0;
                end
                exp_q.push_back(r);
            end else if (acc_clr) begin
                model_acc = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (got_q.size() >= exp_q.size() && !out_valid) break;
            tick();
        end
    endtask

    task automatic beat(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vm, input logic vc);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        mode     = vm;
        acc_clr  = vc;
        tick();
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0;
        acc_clr = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %02h exp 00", out_data); end
        checks++; if (out_parity !== 1'b0) begin errors++; $display("FAIL reset_out_parity got %0b exp 0", out_parity); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_mode0();
        out_ready = 1'b1; mode = 1'b0; acc_clr = 1'b0;
        in_valid = 1'b1; a = 8'hF0; b = 8'h0F;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m0_lat1_valid got %0b exp 0", out_valid); end
        a = 8'hAA; b = 8'hAA;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin errors++; $display("FAIL m0_first got v=%0b d=%02h exp v=1 d=ff", out_valid, out_data); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin errors++; $display("FAIL m0_second got v=%0b d=%02h exp v=1 d=00", out_valid, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m0_end_valid got %0b exp 0", out_valid); end
        drain();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL m0_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i] || got_par_q[i] !== exp_par(exp_q[i])) begin errors++; $display("FAIL m0_data[%0d] got %02h/%0b exp %02h/%0b", i, got_q[i], got_par_q[i], exp_q[i], exp_par(exp_q[i])); end
        end
        got_q.delete(); got_par_q.delete(); exp_q.delete();
    endtask

    task automatic test_accum();
        logic [WIDTH-1:0] want [4];
        want = '{8'h03, 8'h07, 8'h07, 8'h07};
        out_ready = 1'b1;
        beat(8'h01, 8'h02, 1'b1, 1'b0);
        beat(8'h04, 8'h00, 1'b1, 1'b0);
        beat(8'h10, 8'h10, 1'b1, 1'b0);
        beat(8'h00, 8'h00, 1'b1, 1'b0);
        drain();
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL acc_count got %0d exp 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            checks++; if (got_q[i] !== want[i] || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL acc_data[%0d] got %02h exp %02h", i, got_q[i], want[i]); end
            checks++; if (got_par_q[i] !== exp_par(want[i])) begin errors++; $display("FAIL acc_parity[%0d] got %0b exp %0b", i, got_par_q[i], exp_par(want[i])); end
        end
        got_q.delete(); got_par_q.delete(); exp_q.delete();
    endtask

    task automatic test_clr();
        logic [WIDTH-1:0] want [6];
        want = '{8'hFF, 8'h3C, 8'h3C, 8'h00, 8'hFF, 8'h00};
        out_ready = 1'b1;
        beat(8'hF8, 8'h00, 1'b1, 1'b0);
        beat(8'h3C, 8'h00, 1'b1, 1'b1);
        beat(8'h00, 8'h00, 1'b1, 1'b0);
        drain();
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL clr_alone_no_output got %0d results exp 3", got_q.size()); end
        beat(8'h00, 8'h00, 1'b1, 1'b0);
        beat(8'h55, 8'hAA, 1'b0, 1'b1);
        beat(8'h00, 8'h00, 1'b1, 1'b0);
        drain();
        checks++; if (got_q.size() != 6) begin errors++; $display("FAIL clr_count got %0d exp 6", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            checks++; if (got_q[i] !== want[i] || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL clr_data[%0d] got %02h exp %02h", i, got_q[i], want[i]); end
        end
        got_q.delete(); got_par_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] bp_a [4];
        logic [WIDTH-1:0] held;
        int idx;
        int budget;
        bp_a = '{8'h11, 8'h22, 8'h33, 8'h44};
        idx = 0;
        out_ready = 1'b0; in_valid = 1'b1; mode = 1'b0; acc_clr = 1'b0; b = 8'h0F;
        for (int i = 0; i < 4; i++) begin
            a = bp_a[idx];
            tick();
            if (last_in) idx++;
        end
        checks++; if (idx != 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", idx); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %0b exp 1", out_valid); end
        held = out_data;
        tick();
        tick();
        checks++; if (out_data !== held || out_data !== (8'h11 ^ 8'h0F)) begin errors++; $display("FAIL bp_stable got %02h exp %02h", out_data, 8'h11 ^ 8'h0F); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b exp 1", in_ready); end
        budget = 0;
        while (idx < 4 && budget < 20) begin
            a = bp_a[idx];
            tick();
            if (last_in) idx++;
            budget++;
        end
        checks++; if (idx != 4) begin errors++; $display("FAIL bp_timeout accepted %0d exp 4", idx); end
        drain();
        checks++; if (got_q.size() != 4 || exp_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            checks++; if (got_q[i] !== (bp_a[i] ^ 8'h0F) || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d] got %02h exp %02h", i, got_q[i], bp_a[i] ^ 8'h0F); end
        end
        got_q.delete(); got_par_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1; mode = 1'b1; acc_clr = 1'b0; in_valid = 1'b1;
        a = 8'h5A; b = 8'h00;
        tick();
        a = 8'h0F;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rstmid_out got v=%0b d=%02h exp v=0 d=00", out_valid, out_data); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rstmid_stale got %0d results exp 0", got_q.size()); end
        beat(8'h00, 8'h00, 1'b1, 1'b0);
        drain();
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h00 || exp_q[0] !== 8'h00) begin errors++; $display("FAIL rstmid_acc got %0d results first %02h exp 1 result 00", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
        got_q.delete(); got_par_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_accum();
        test_clr();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
